// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator: 1-bit PDM stream in, signed W-bit PCM out at 1/R rate.
// Integrators run on din_en strobes; combs, scaling and saturation run once per block.
module pdm_cic_decimator #(
  parameter int unsigned W     = 16,
  parameter int unsigned LOG2R = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din_en,
  input  logic                din,
  output logic signed [W-1:0] dout,
  output logic                dout_valid
);

  localparam int unsigned AW = 3 * LOG2R + 2;
  localparam int unsigned SH = 3 * LOG2R + 1 - W;
  localparam logic signed [AW-1:0] PMAX = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] NMIN = AW'(-(2 ** (W - 1)));

  logic signed [AW-1:0] i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic signed [AW-1:0] s_q, s_d;
  logic signed [AW-1:0] c1_q, c2_q, c3_q, c1_d, c2_d, c3_d;
  logic [LOG2R-1:0]     dcnt_q, dcnt_d;
  logic [1:0]           warm_q, warm_d;
  logic                 fire_q, fire_d;
  logic                 pend_q, pend_d;
  logic signed [W-1:0]  smp_q, smp_d;
  logic signed [W-1:0]  dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;

  logic signed [AW-1:0] x_c, i1_n_c, i2_n_c, i3_n_c;
  logic signed [AW-1:0] y1_c, y2_c, y3_c, sh_c;
  logic signed [W-1:0]  sat_c;

  // Cascaded integrator next-values and comb/scale datapath.
  always_comb begin
    x_c    = din ? AW'(1) : {AW{1'b1}};
    i1_n_c = i1_q + x_c;
    i2_n_c = i2_q + i1_n_c;
    i3_n_c = i3_q + i2_n_c;
    y1_c   = s_q - c1_q;
    y2_c   = y1_c - c2_q;
    y3_c   = y2_c - c3_q;
    sh_c   = y3_c >>> SH;
    if (sh_c > PMAX) begin
      sat_c = W'(PMAX);
    end else if (sh_c < NMIN) begin
      sat_c = W'(NMIN);
    end else begin
      sat_c = W'(sh_c);
    end
  end

  // Next-state: strobe path, comb stage (edge after block end), output stage.
  always_comb begin
    i1_d         = i1_q;
    i2_d         = i2_q;
    i3_d         = i3_q;
    dcnt_d       = dcnt_q;
    s_d          = s_q;
    fire_d       = 1'b0;
    c1_d         = c1_q;
    c2_d         = c2_q;
    c3_d         = c3_q;
    warm_d       = warm_q;
    pend_d       = 1'b0;
    smp_d        = smp_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (din_en) begin
      i1_d   = i1_n_c;
      i2_d   = i2_n_c;
      i3_d   = i3_n_c;
      dcnt_d = dcnt_q + LOG2R'(1);
      if (&dcnt_q) begin
        s_d    = i3_n_c;
        fire_d = 1'b1;
      end
    end

    if (fire_q) begin
      c1_d  = s_q;
      c2_d  = y1_c;
      c3_d  = y2_c;
      smp_d = sat_c;
      // Comb delays are not yet primed for the first three blocks.
      if (warm_q == 2'd3) begin
        pend_d = 1'b1;
      end else begin
        warm_d = warm_q + 2'd1;
      end
    end

    if (pend_q) begin
      dout_d       = smp_q;
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q         <= '0;
      i2_q         <= '0;
      i3_q         <= '0;
      dcnt_q       <= '0;
      s_q          <= '0;
      fire_q       <= 1'b0;
      c1_q         <= '0;
      c2_q         <= '0;
      c3_q         <= '0;
      warm_q       <= '0;
      pend_q       <= 1'b0;
      smp_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      i3_q         <= i3_d;
      dcnt_q       <= dcnt_d;
      s_q          <= s_d;
      fire_q       <= fire_d;
      c1_q         <= c1_d;
      c2_q         <= c2_d;
      c3_q         <= c3_d;
      warm_q       <= warm_d;
      pend_q       <= pend_d;
      smp_q        <= smp_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: reference is a direct FIR with the triple-boxcar kernel
// applied to the history of +/-1 input bits, evaluated every R strobes.
module tb_pdm_cic_decimator;

  localparam int W     = 16;
  localparam int LOG2R = 6;
  localparam int R     = 1 << LOG2R;
  localparam int KL    = 3 * R - 2;
  localparam int SH    = 3 * LOG2R + 1 - W;

  logic                clk;
  logic                rst_n;
  logic                din_en;
  logic                din;
  logic signed [W-1:0] dout;
  logic                dout_valid;

  pdm_cic_decimator #(.W(W), .LOG2R(LOG2R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_en     (din_en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int due; int val;} ev_t;
  typedef struct {logic [3:0] pat; int period; int blocks; int exp_dout;} vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   h[KL];
  int   hist[$];
  ev_t  pend[$];
  int   t = 0;
  int   nbits = 0;
  int   nev = 0;
  int   held = 0;
  int   dut_nv = 0;
  int   dut_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (iter %0d)", name, act, exp, t);
    end
  endtask

  // Kernel of three cascaded length-R moving sums.
  task automatic build_kernel();
    int h2[2*R-1];
    for (int k = 0; k < 2*R-1; k++) h2[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++) h2[a+b]++;
    for (int j = 0; j < KL; j++) begin
      h[j] = 0;
      for (int c = 0; c < R; c++)
        if (j - c >= 0 && j - c < 2*R-1) h[j] += h2[j-c];
    end
  endtask

  task automatic model_step(input logic en, input logic b);
    int y;
    int q;
    if (en) begin
      hist.push_front(b ? 1 : -1);
      if (hist.size() > KL) void'(hist.pop_back());
      nbits++;
      if (nbits % R == 0) begin
        nev++;
        if (nev > 3) begin
          y = 0;
          for (int j = 0; j < hist.size(); j++) y += h[j] * hist[j];
          q = y >>> SH;
          if (q > 32767) q = 32767;
          if (q < -32768) q = -32768;
          pend.push_back('{t + 3, q});
        end
      end
    end
  endtask

  task automatic cycle(input logic en, input logic b);
    bit ev;
    @(negedge clk);
    rst_n = 1'b1;
    ev = (pend.size() > 0) && (pend[0].due == t);
    chk("dout_valid", int'(dout_valid), int'(ev));
    if (ev) begin
      held = pend[0].val;
      void'(pend.pop_front());
    end
    chk("dout", int'(dout), held);
    if (dout_valid === 1'b1) begin
      dut_nv++;
      dut_last = int'(dout);
    end
    din_en = en;
    din    = b;
    model_step(en, b);
    t++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    din_en = 1'b0;
    din    = 1'b0;
    #1;
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_valid", int'(dout_valid), 0);
    hist.delete();
    pend.delete();
    nbits = 0; nev = 0; held = 0; dut_nv = 0; dut_last = 0;
    t++;
  endtask

  task automatic run_bits(input logic [3:0] pat, input int period, input int nstrobes);
    for (int k = 0; k < nstrobes; k++) begin
      cycle(1'b1, pat[3 - (k % 4)]);
      if (period > 1)
        repeat (period - 1 + int'($urandom_range(0, 2))) cycle(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic flush();
    repeat (4) cycle(1'b0, 1'b0);
  endtask

  initial begin
    vec_t vt[5];
    rst_n  = 1'b0;
    din_en = 1'b0;
    din    = 1'b0;
    build_kernel();
    vt[0] = '{4'b1111, 1, 6, 32767};
    vt[1] = '{4'b0000, 1, 6, -32768};
    vt[2] = '{4'b1010, 1, 6, 0};
    vt[3] = '{4'b1110, 1, 6, 16384};
    vt[4] = '{4'b1110, 4, 6, 16384};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_bits(vt[i].pat, vt[i].period, vt[i].blocks * R);
      flush();
      chk("vec_last_dout", dut_last, vt[i].exp_dout);
      chk("vec_valid_count", dut_nv, vt[i].blocks - 3);
      chk("vec_pend_empty", pend.size(), 0);
    end

    // Random bits with random strobe gaps.
    do_reset();
    repeat (1500) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    flush();
    chk("rand_pend_empty", pend.size(), 0);

    // Reset mid-block, then warm-up must restart.
    do_reset();
    run_bits(4'b1111, 1, 5 * R + 20);
    chk("pre_rst_dout", dut_last, 32767);
    do_reset();
    run_bits(4'b1111, 1, 3 * R);
    flush();
    chk("warmup_no_valid", dut_nv, 0);
    run_bits(4'b1111, 1, R);
    flush();
    chk("post_rst_valid_count", dut_nv, 1);
    chk("post_rst_dout", dut_last, 32767);

    // Long full-scale run through integrator wrap-around.
    do_reset();
    run_bits(4'b1111, 1, 40 * R);
    flush();
    chk("long_valid_count", dut_nv, 37);
    chk("long_dout", dut_last, 32767);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
